morse_key_timer: RTL and testbench

- Front-end stage directly upstream of the Morse character decoder.
- Samples a raw, asynchronous telegraph-key level, then synchronises and debounces it.
- Measures key-down and key-up durations in clock cycles.
- Emits single-cycle dot / dash / lg (letter gap) / wg (word gap) pulses, which the decoder consumes on its clk, plus an error pulse for over-long presses.

---
 rtl/morse_pkg.sv | 22 ++
 rtl/key_debouncer.sv | 51 +++++
 rtl/morse_key_timer.sv | 147 ++++++++++++++
 tb/tb_morse_key_timer.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/morse_pkg.sv
// Shared Morse timing definitions: FSM state encoding and threshold multipliers
// expressed in Morse time units, used by the key timer and the character decoder.
package morse_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        PRESS     = 3'd1,
        GAP       = 3'd2,
        WAIT_WORD = 3'd3,
        LOCKOUT   = 3'd4
    } state_e;

    localparam int DASH_MIN_U  = 2;
    localparam int PRESS_MAX_U = 8;
    localparam int LG_U        = 2;
    localparam int WG_U        = 5;

    function automatic int units_to_cycles(input int units, input int unit_cycles);
        return units * unit_cycles;
    endfunction

endpackage

// File: rtl/key_debouncer.sv
// Two-flop synchroniser for the raw key level followed by a debounce counter
// that accepts a level change only after DEB_CYCLES consecutive differing samples.
module key_debouncer #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic key_db
);

    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             sync1_q;
    logic             key_s_q;
    logic             key_db_q;
    logic             key_db_d;
    logic [CNT_W-1:0] deb_cnt_q;
    logic [CNT_W-1:0] deb_cnt_d;

    // The counter restarts on any agreeing sample, so only an unbroken run toggles key_db.
    always_comb begin
        deb_cnt_d = '0;
        key_db_d  = key_db_q;
        if (key_s_q != key_db_q) begin
            if (deb_cnt_q == DEB_LAST) begin
                key_db_d = key_s_q;
            end else begin
                deb_cnt_d = deb_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= 1'b0;
            key_s_q   <= 1'b0;
            key_db_q  <= 1'b0;
            deb_cnt_q <= '0;
        end else begin
            sync1_q   <= key_in;
            key_s_q   <= sync1_q;
            key_db_q  <= key_db_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    assign key_db = key_db_q;

endmodule

// File: rtl/morse_key_timer.sv
// Morse key front end: debounced key level, press/gap duration counter and the
// classification FSM that emits one-cycle dot/dash/lg/wg/error pulses.
module morse_key_timer
    import morse_pkg::*;
#(
    parameter int UNIT_CYCLES = 10,
    parameter int DEB_CYCLES  = 4,
    parameter int CNT_W       = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_in,
    output logic dot,
    output logic dash,
    output logic lg,
    output logic wg,
    output logic error,
    output logic key_db
);

    // dur is cleared in an edge cycle, so it reads k-2 in the k-th cycle of a level
    // and length-1 in the first cycle after a level of that length ends.
    localparam logic [CNT_W-1:0] DASH_MIN_DUR = CNT_W'(units_to_cycles(DASH_MIN_U, UNIT_CYCLES) - 1);
    localparam logic [CNT_W-1:0] PRESS_MAX_HIT = CNT_W'(units_to_cycles(PRESS_MAX_U, UNIT_CYCLES) - 2);
    localparam logic [CNT_W-1:0] LG_HIT = CNT_W'(units_to_cycles(LG_U, UNIT_CYCLES) - 2);
    localparam logic [CNT_W-1:0] WG_HIT = CNT_W'(units_to_cycles(WG_U, UNIT_CYCLES) - 2);

    logic             key_db_w;
    logic             key_db_dly_q;
    logic             rise;
    logic             fall;
    logic [CNT_W-1:0] dur_q;
    logic [CNT_W-1:0] dur_d;
    state_e           state_q;
    state_e           state_d;
    logic             dot_q,   dot_d;
    logic             dash_q,  dash_d;
    logic             lg_q,    lg_d;
    logic             wg_q,    wg_d;
    logic             error_q, error_d;

    key_debouncer #(
        .DEB_CYCLES (DEB_CYCLES),
        .CNT_W      (CNT_W)
    ) u_debouncer (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .key_db (key_db_w)
    );

    assign rise = key_db_w & ~key_db_dly_q;
    assign fall = ~key_db_w & key_db_dly_q;

    always_comb begin
        dur_d = dur_q;
        if (rise || fall) begin
            dur_d = '0;
        end else if (dur_q != '1) begin
            dur_d = dur_q + CNT_W'(1);
        end
    end

    // Edges are tested before thresholds, so a rise coinciding with a threshold wins.
    always_comb begin
        state_d = state_q;
        dot_d   = 1'b0;
        dash_d  = 1'b0;
        lg_d    = 1'b0;
        wg_d    = 1'b0;
        error_d = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = PRESS;
                end
            end
            PRESS: begin
                if (fall) begin
                    if (dur_q >= DASH_MIN_DUR) begin
                        dash_d = 1'b1;
                    end else begin
                        dot_d = 1'b1;
                    end
                    state_d = GAP;
                end else if (dur_q == PRESS_MAX_HIT) begin
                    error_d = 1'b1;
                    state_d = LOCKOUT;
                end
            end
            GAP: begin
                if (rise) begin
                    state_d = PRESS;
                end else if (dur_q == LG_HIT) begin
                    lg_d    = 1'b1;
                    state_d = WAIT_WORD;
                end
            end
            WAIT_WORD: begin
                if (rise) begin
                    state_d = PRESS;
                end else if (dur_q == WG_HIT) begin
                    wg_d    = 1'b1;
                    state_d = IDLE;
                end
            end
            LOCKOUT: begin
                if (fall) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_db_dly_q <= 1'b0;
            dur_q        <= '0;
            state_q      <= IDLE;
            dot_q        <= 1'b0;
            dash_q       <= 1'b0;
            lg_q         <= 1'b0;
            wg_q         <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            key_db_dly_q <= key_db_w;
            dur_q        <= dur_d;
            state_q      <= state_d;
            dot_q        <= dot_d;
            dash_q       <= dash_d;
            lg_q         <= lg_d;
            wg_q         <= wg_d;
            error_q      <= error_d;
        end
    end

    assign dot    = dot_q;
    assign dash   = dash_q;
    assign lg     = lg_q;
    assign wg     = wg_q;
    assign error  = error_q;
    assign key_db = key_db_w;

endmodule

// File: tb/tb_morse_key_timer.sv
// Directed bench for morse_key_timer (UNIT_CYCLES=10, DEB_CYCLES=4): each task
// drives a key pattern and compares pulse counts and timing against hand values.
module tb_morse_key_timer;

    localparam int UNIT = 10;
    localparam int DEB  = 4;

    logic clk    = 1'b0;
    logic rst_n  = 1'b0;
    logic key_in = 1'b0;
    logic dot, dash, lg, wg, error, key_db;

    morse_key_timer #(
        .UNIT_CYCLES (UNIT),
        .DEB_CYCLES  (DEB),
        .CNT_W       (16)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .key_in (key_in),
        .dot    (dot),
        .dash   (dash),
        .lg     (lg),
        .wg     (wg),
        .error  (error),
        .key_db (key_db)
    );

    always #5 clk = ~clk;

    int    vectors     = 0;
    int    miscompares = 0;
    int    cyc         = 0;
    int    pcnt[5];
    int    pfirst[5];
    int    plast[5];
    int    multi_hot;
    int    db_high;
    string pname[5] = '{"dot", "dash", "lg", "wg", "error"};

    // Advance n cycles, sampling 1 time unit after each rising edge.
    task automatic step(input int n);
        logic [4:0] p;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            cyc++;
            p = {error, wg, lg, dash, dot};
            for (int k = 0; k < 5; k++) begin
                if (p[k]) begin
                    if (pcnt[k] == 0) pfirst[k] = cyc;
                    plast[k] = cyc;
                    pcnt[k]++;
                end
            end
            if ($countones(p) > 1) multi_hot++;
            if (key_db) db_high++;
        end
    endtask

    task automatic clear_stats();
        for (int k = 0; k < 5; k++) begin
            pcnt[k]   = 0;
            pfirst[k] = 0;
            plast[k]  = 0;
        end
        multi_hot = 0;
        db_high   = 0;
    endtask

    task automatic do_reset();
        key_in = 1'b0;
        rst_n  = 1'b0;
        step(2);
        rst_n = 1'b1;
        step(2);
    endtask

    task automatic test_reset();
        logic [5:0] outs;
        rst_n  = 1'b0;
        key_in = 1'b0;
        step(2);
        outs = {dot, dash, lg, wg, error, key_db};
        vectors++;
        if (outs !== 6'b0) begin
            $display("FAIL reset_outputs: got %b expected 000000", outs);
            miscompares++;
        end
        rst_n = 1'b1;
        clear_stats();
        step(20);
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== 0) begin
                $display("FAIL reset_idle %s count: got %0d expected 0", pname[k], pcnt[k]);
                miscompares++;
            end
        end
        vectors++;
        if (db_high !== 0) begin
            $display("FAIL reset_idle key_db high cycles: got %0d expected 0", db_high);
            miscompares++;
        end
    endtask

    task automatic test_dot_word();
        int t0;
        int exp_cnt[5];
        int exp_t[5];
        do_reset();
        clear_stats();
        t0 = cyc;
        key_in = 1'b1; step(10);
        key_in = 1'b0; step(80);
        exp_cnt = '{1, 0, 1, 1, 0};
        exp_t   = '{t0 + 17, 0, t0 + 36, t0 + 66, 0};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== exp_cnt[k]) begin
                $display("FAIL dot_word %s count: got %0d expected %0d", pname[k], pcnt[k], exp_cnt[k]);
                miscompares++;
            end
            if (exp_cnt[k] != 0) begin
                vectors++;
                if (pfirst[k] !== exp_t[k]) begin
                    $display("FAIL dot_word %s cycle: got %0d expected %0d", pname[k], pfirst[k] - t0, exp_t[k] - t0);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (multi_hot !== 0) begin
            $display("FAIL dot_word multi_hot cycles: got %0d expected 0", multi_hot);
            miscompares++;
        end
    endtask

    task automatic test_letter_a();
        int t0;
        int exp_cnt[5];
        int exp_t[5];
        do_reset();
        clear_stats();
        t0 = cyc;
        key_in = 1'b1; step(10);
        key_in = 1'b0; step(10);
        key_in = 1'b1; step(30);
        key_in = 1'b0; step(30);
        exp_cnt = '{1, 1, 1, 0, 0};
        exp_t   = '{t0 + 17, t0 + 57, t0 + 76, 0, 0};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== exp_cnt[k]) begin
                $display("FAIL letter_a %s count: got %0d expected %0d", pname[k], pcnt[k], exp_cnt[k]);
                miscompares++;
            end
            if (exp_cnt[k] != 0) begin
                vectors++;
                if (pfirst[k] !== exp_t[k]) begin
                    $display("FAIL letter_a %s cycle: got %0d expected %0d", pname[k], pfirst[k] - t0, exp_t[k] - t0);
                    miscompares++;
                end
            end
        end
        vectors++;
        if (multi_hot !== 0) begin
            $display("FAIL letter_a multi_hot cycles: got %0d expected 0", multi_hot);
            miscompares++;
        end
    endtask

    // Press 19 -> dot, gap 19 -> no lg, press 20 -> dash, then a trailing lg.
    task automatic test_boundaries();
        int t0;
        int exp_cnt[5];
        int exp_t[5];
        do_reset();
        clear_stats();
        t0 = cyc;
        key_in = 1'b1; step(19);
        key_in = 1'b0; step(19);
        key_in = 1'b1; step(20);
        key_in = 1'b0; step(30);
        exp_cnt = '{1, 1, 1, 0, 0};
        exp_t   = '{t0 + 26, t0 + 65, t0 + 84, 0, 0};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== exp_cnt[k]) begin
                $display("FAIL boundaries %s count: got %0d expected %0d", pname[k], pcnt[k], exp_cnt[k]);
                miscompares++;
            end
            if (exp_cnt[k] != 0) begin
                vectors++;
                if (pfirst[k] !== exp_t[k]) begin
                    $display("FAIL boundaries %s cycle: got %0d expected %0d", pname[k], pfirst[k] - t0, exp_t[k] - t0);
                    miscompares++;
                end
            end
        end
    endtask

    // A gap of exactly 20 cycles reaches the letter-gap threshold before the rise.
    task automatic test_gap_exact();
        int t0;
        do_reset();
        clear_stats();
        t0 = cyc;
        key_in = 1'b1; step(10);
        key_in = 1'b0; step(20);
        key_in = 1'b1; step(10);
        key_in = 1'b0; step(10);
        vectors++;
        if (pcnt[2] !== 1 || pfirst[2] !== t0 + 36) begin
            $display("FAIL gap_exact lg: got count %0d at %0d expected count 1 at 36", pcnt[2], pfirst[2] - t0);
            miscompares++;
        end
        vectors++;
        if (pcnt[0] !== 2 || plast[0] !== t0 + 47) begin
            $display("FAIL gap_exact dot: got count %0d last %0d expected count 2 last 47", pcnt[0], plast[0] - t0);
            miscompares++;
        end
    endtask

    task automatic test_glitch();
        do_reset();
        clear_stats();
        for (int g = 0; g < 5; g++) begin
            step(17);
            key_in = 1'b1; step(3);
            key_in = 1'b0;
        end
        step(10);
        vectors++;
        if (db_high !== 0) begin
            $display("FAIL glitch key_db high cycles: got %0d expected 0", db_high);
            miscompares++;
        end
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== 0) begin
                $display("FAIL glitch %s count: got %0d expected 0", pname[k], pcnt[k]);
                miscompares++;
            end
        end
    endtask

    task automatic test_overlong();
        int t0;
        int exp_cnt[5];
        do_reset();
        clear_stats();
        t0 = cyc;
        key_in = 1'b1; step(100);
        key_in = 1'b0; step(80);
        exp_cnt = '{0, 0, 0, 0, 1};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== exp_cnt[k]) begin
                $display("FAIL overlong %s count: got %0d expected %0d", pname[k], pcnt[k], exp_cnt[k]);
                miscompares++;
            end
        end
        vectors++;
        if (pfirst[4] !== t0 + 86) begin
            $display("FAIL overlong error cycle: got %0d expected 86", pfirst[4] - t0);
            miscompares++;
        end
    endtask

    task automatic test_reset_mid_press();
        int t1;
        int exp_cnt[5];
        int exp_t[5];
        logic [5:0] outs;
        do_reset();
        clear_stats();
        key_in = 1'b1; step(15);
        rst_n = 1'b0;
        #1;
        outs = {dot, dash, lg, wg, error, key_db};
        vectors++;
        if (outs !== 6'b0) begin
            $display("FAIL mid_press_reset outputs: got %b expected 000000", outs);
            miscompares++;
        end
        step(2);
        rst_n = 1'b1;
        t1 = cyc;
        step(5);
        vectors++;
        if (key_db !== 1'b0) begin
            $display("FAIL mid_press key_db early: got %b expected 0", key_db);
            miscompares++;
        end
        step(1);
        vectors++;
        if (key_db !== 1'b1) begin
            $display("FAIL mid_press key_db rise: got %b expected 1", key_db);
            miscompares++;
        end
        step(10);
        key_in = 1'b0; step(40);
        exp_cnt = '{1, 0, 1, 0, 0};
        exp_t   = '{t1 + 23, 0, t1 + 42, 0, 0};
        for (int k = 0; k < 5; k++) begin
            vectors++;
            if (pcnt[k] !== exp_cnt[k]) begin
                $display("FAIL mid_press %s count: got %0d expected %0d", pname[k], pcnt[k], exp_cnt[k]);
                miscompares++;
            end
            if (exp_cnt[k] != 0) begin
                vectors++;
                if (pfirst[k] !== exp_t[k]) begin
                    $display("FAIL mid_press %s cycle: got %0d expected %0d", pname[k], pfirst[k] - t1, exp_t[k] - t1);
                    miscompares++;
                end
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_dot_word();
        test_letter_a();
        test_boundaries();
        test_gap_exact();
        test_glitch();
        test_overlong();
        test_reset_mid_press();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
